// File: rtl/isp_mode_sync.sv
// Frame-synchronous ISP mode switch with post-switch output muting and a registered pixel path.
// Build macro ISP_MODE_SYNC_KEY_EN adds a debounced key_n push button that steps the mode.
module isp_mode_sync #(
  parameter int MAX_MODE    = 5,
  parameter int RESET_MODE  = 0,
  parameter int MUTE_FRAMES = 2,
  parameter bit VS_POL      = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
`ifdef ISP_MODE_SYNC_KEY_EN
  input  logic        key_n,
`endif
  input  logic [3:0]  mode_req,
  input  logic        mode_req_valid,
  input  logic        vsync_in,
  input  logic        de_in,
  input  logic [23:0] pix_in,
  output logic [3:0]  mode,
  output logic [23:0] pix_out,
  output logic        de_out,
  output logic        vsync_out,
  output logic        switching,
  output logic        req_err
);

  // state   | meaning
  // IDLE    | applied mode stable, pixels pass
  // PENDING | request held until the next frame edge
  // MUTE    | new mode applied, output blanked until the mute count expires
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    MUTE    = 2'd2
  } state_t;

  localparam logic [3:0] MAX_M     = 4'(MAX_MODE);
  localparam logic [3:0] RST_M     = 4'(RESET_MODE);
  localparam logic [3:0] MUTE_INIT = 4'(MUTE_FRAMES);
  localparam bit         MUTE_EN   = (MUTE_FRAMES != 0);

  state_t     state, state_nx;
  logic [3:0] mode_nx;
  logic [3:0] pend_mode, pend_mode_nx;
  logic       pend, pend_nx;
  logic [3:0] mute_cnt, mute_cnt_nx;
  logic       vs_n, vs_prev, frame_edge;
  logic       req_valid;
  logic [3:0] req_mode;
  logic       req_legal, req_bad, accept;

  assign vs_n       = ~(vsync_in ^ VS_POL);
  assign frame_edge = vs_n & ~vs_prev;

`ifdef ISP_MODE_SYNC_KEY_EN
  logic [1:0]  key_sync;
  logic        key_db;
  logic [19:0] db_cnt;
  logic        key_press;
  logic [3:0]  key_mode;

  // key_db is the debounced level (1 = released); it follows key_sync only after 2^20 stable cycles
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      key_sync <= 2'b11;
      key_db   <= 1'b1;
      db_cnt   <= '0;
    end else begin
      key_sync <= {key_sync[0], key_n};
      if (key_sync[1] == key_db) begin
        db_cnt <= '0;
      end else if (db_cnt == '1) begin
        key_db <= key_sync[1];
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 20'd1;
      end
    end
  end

  assign key_press = (db_cnt == '1) && (key_sync[1] != key_db) && !key_sync[1];
  assign key_mode  = (mode >= MAX_M) ? 4'd0 : mode + 4'd1;
  assign req_valid = mode_req_valid | key_press;
  assign req_mode  = mode_req_valid ? mode_req : key_mode;
`else
  assign req_valid = mode_req_valid;
  assign req_mode  = mode_req;
`endif

  assign req_legal = req_valid && (req_mode <= MAX_M);
  assign req_bad   = mode_req_valid && (mode_req > MAX_M);
  assign accept    = req_legal && !((state == IDLE) && (req_mode == mode));

  always_comb begin
    state_nx     = state;
    mode_nx      = mode;
    pend_nx      = pend;
    pend_mode_nx = pend_mode;
    mute_cnt_nx  = mute_cnt;
    if (accept) begin
      pend_nx      = 1'b1;
      pend_mode_nx = req_mode;
    end
    case (state)
      IDLE: begin
        if (accept) state_nx = PENDING;
      end
      PENDING: begin
        if (frame_edge) begin
          mode_nx = pend_mode;
          pend_nx = accept;
          if (MUTE_EN) begin
            mute_cnt_nx = MUTE_INIT;
            state_nx    = MUTE;
          end else begin
            state_nx = accept ? PENDING : IDLE;
          end
        end
      end
      MUTE: begin
        if (frame_edge) begin
          mute_cnt_nx = mute_cnt - 4'd1;
          // a request landing on the last muted edge still waits for a fresh frame
          if (mute_cnt == 4'd1) state_nx = (pend || accept) ? PENDING : IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      mode      <= RST_M;
      pend      <= 1'b0;
      pend_mode <= '0;
      mute_cnt  <= '0;
      vs_prev   <= 1'b0;
      switching <= 1'b0;
      req_err   <= 1'b0;
      pix_out   <= '0;
      de_out    <= 1'b0;
      vsync_out <= 1'b0;
    end else begin
      state     <= state_nx;
      mode      <= mode_nx;
      pend      <= pend_nx;
      pend_mode <= pend_mode_nx;
      mute_cnt  <= mute_cnt_nx;
      vs_prev   <= vs_n;
      switching <= (state_nx != IDLE);
      req_err   <= req_bad;
      pix_out   <= ((state == MUTE) || !de_in) ? 24'd0 : pix_in;
      de_out    <= de_in;
      vsync_out <= vsync_in;
    end
  end

endmodule

// File: tb/tb_isp_mode_sync.sv
// Self-checking bench for isp_mode_sync: directed scenarios plus randomized traffic against a frame-level model.
`timescale 1ns/1ps
module tb_isp_mode_sync;

  localparam int MAX_MODE    = 5;
  localparam int RESET_MODE  = 0;
  localparam int MUTE_FRAMES = 2;
  localparam bit VS_POL      = 1'b1;
  localparam int FLEN        = 32;
  localparam int VS_LEN      = 3;
  localparam int DE_FIRST    = 4;
  localparam int DE_LAST     = 30;
  localparam int DE_PER_FRAME = DE_LAST - DE_FIRST + 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  mode_req = 4'd0;
  logic        mode_req_valid = 1'b0;
  logic        vsync_in = ~VS_POL;
  logic        de_in = 1'b0;
  logic [23:0] pix_in = 24'd0;
  logic [3:0]  mode;
  logic [23:0] pix_out;
  logic        de_out, vsync_out, switching, req_err;

  always #5 clk = ~clk;

  isp_mode_sync #(
    .MAX_MODE(MAX_MODE), .RESET_MODE(RESET_MODE), .MUTE_FRAMES(MUTE_FRAMES), .VS_POL(VS_POL)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
`ifdef ISP_MODE_SYNC_KEY_EN
    .key_n(1'b1),
`endif
    .mode_req(mode_req),
    .mode_req_valid(mode_req_valid),
    .vsync_in(vsync_in),
    .de_in(de_in),
    .pix_in(pix_in),
    .mode(mode),
    .pix_out(pix_out),
    .de_out(de_out),
    .vsync_out(vsync_out),
    .switching(switching),
    .req_err(req_err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Frame-level model: applied mode, one held request and frames of blanking still owed.
  logic [3:0]  m_mode, m_pend_mode;
  bit          m_pend, m_vsprev, m_valid;
  int          m_mute;
  bit          m_vsn, m_fedge, m_legal, m_take, m_idle;
  logic [3:0]  e_mode;
  bit          e_sw, e_err, e_de, e_vs;
  logic [23:0] e_pix;

  initial begin
    m_valid = 1'b0;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        m_mode = 4'(RESET_MODE); m_pend = 1'b0; m_pend_mode = 4'd0; m_mute = 0; m_vsprev = 1'b0;
        e_err = 1'b0; e_pix = 24'd0; e_de = 1'b0; e_vs = 1'b0;
        m_valid = 1'b1;
      end else begin
        m_vsn   = (vsync_in == VS_POL);
        m_fedge = m_vsn && !m_vsprev;
        m_vsprev = m_vsn;
        m_legal = mode_req_valid && (int'(mode_req) <= MAX_MODE);
        m_idle  = !m_pend && (m_mute == 0);
        m_take  = m_legal && !(m_idle && (mode_req == m_mode));
        e_pix   = ((m_mute > 0) || !de_in) ? 24'd0 : pix_in;
        e_err   = mode_req_valid && (int'(mode_req) > MAX_MODE);
        e_de    = de_in;
        e_vs    = vsync_in;
        if (m_fedge) begin
          if (m_mute > 0) m_mute--;
          else if (m_pend) begin
            m_mode = m_pend_mode;
            m_pend = 1'b0;
            m_mute = MUTE_FRAMES;
          end
        end
        if (m_take) begin
          m_pend = 1'b1;
          m_pend_mode = mode_req;
        end
      end
      e_mode = m_mode;
      e_sw   = m_pend || (m_mute > 0);
      @(negedge clk);
      if (m_valid) begin
        check("mode",      32'(mode),      32'(e_mode));
        check("switching", 32'(switching), 32'(e_sw));
        check("req_err",   32'(req_err),   32'(e_err));
        check("de_out",    32'(de_out),    32'(e_de));
        check("vsync_out", 32'(vsync_out), 32'(e_vs));
        check("pix_out",   32'(pix_out),   32'(e_pix));
      end
    end
  end

  int fpos = 10;
  bit rand_de = 1'b0;
  bit fixed_en = 1'b0;
  logic [23:0] fixed_val = 24'd0;

  task automatic cyc(input bit rv, input logic [3:0] rm);
    logic [31:0] r;
    @(posedge clk);
    #2;
    r = $urandom();
    vsync_in = (fpos < VS_LEN) ? VS_POL : ~VS_POL;
    de_in = (fpos >= DE_FIRST) && (fpos <= DE_LAST) && (!rand_de || ($urandom_range(3) != 0));
    pix_in = fixed_en ? fixed_val : (r[23:0] | 24'h1);
    mode_req_valid = rv;
    mode_req = rm;
    fpos = (fpos + 1) % FLEN;
  endtask

  task automatic wait_mode(input logic [3:0] m, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      cyc(1'b0, 4'd0);
      if (mode == m) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      cyc(1'b0, 4'd0);
      if (!switching) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  // counts blanked data-enable cycles until the first pixel passes; -1 if none within budget
  task automatic measure_mute(output int muted);
    muted = 0;
    for (int i = 0; i < 300; i++) begin
      if (de_out && (pix_out != 24'd0)) return;
      if (de_out) muted++;
      cyc(1'b0, 4'd0);
    end
    muted = -1;
  endtask

  bit ok, saw4, prev_vo;
  int muted, edges;

  initial begin
    // reset and pass-through
    rst_n = 1'b0;
    repeat (3) cyc(1'b0, 4'd0);
    check("rst_mode", 32'(mode), 32'd0);
    check("rst_pix", 32'(pix_out), 32'd0);
    check("rst_switching", 32'(switching), 32'd0);
    rst_n = 1'b1;
    fixed_en = 1'b1; fixed_val = 24'h123456;
    cyc(1'b0, 4'd0);
    fixed_en = 1'b0;
    cyc(1'b0, 4'd0);
    check("pass_pix", 32'(pix_out), 32'h123456);
    check("pass_de", 32'(de_out), 32'd1);

    // mid-frame request for mode 3, two frames blanked
    cyc(1'b1, 4'd3);
    cyc(1'b0, 4'd0);
    check("req3_switching", 32'(switching), 32'd1);
    check("req3_mode_hold", 32'(mode), 32'd0);
    wait_mode(4'd3, 200, ok);
    check("req3_applied", 32'(ok), 32'd1);
    measure_mute(muted);
    check("req3_muted_cycles", 32'(muted), 32'(MUTE_FRAMES * DE_PER_FRAME));
    check("req3_idle_after", 32'(switching), 32'd0);

    // last request in a frame wins
    cyc(1'b1, 4'd4);
    cyc(1'b0, 4'd0);
    cyc(1'b0, 4'd0);
    cyc(1'b1, 4'd5);
    saw4 = 1'b0;
    for (int i = 0; i < 200; i++) begin
      cyc(1'b0, 4'd0);
      if (mode == 4'd4) saw4 = 1'b1;
      if (mode == 4'd5) break;
    end
    check("lastwin_never4", 32'(saw4), 32'd0);
    check("lastwin_mode5", 32'(mode), 32'd5);
    wait_idle(300, ok);
    check("lastwin_idle", 32'(ok), 32'd1);

    // illegal request
    cyc(1'b1, 4'd9);
    cyc(1'b0, 4'd0);
    check("bad_err_pulse", 32'(req_err), 32'd1);
    cyc(1'b0, 4'd0);
    check("bad_err_clear", 32'(req_err), 32'd0);
    check("bad_mode", 32'(mode), 32'd5);
    check("bad_switching", 32'(switching), 32'd0);

    // request during mute of a 1->3 switch
    cyc(1'b1, 4'd1);
    wait_idle(300, ok);
    check("to1_idle", 32'(ok), 32'd1);
    cyc(1'b1, 4'd3);
    wait_mode(4'd3, 200, ok);
    check("to3_applied", 32'(ok), 32'd1);
    repeat (5) cyc(1'b0, 4'd0);
    cyc(1'b1, 4'd2);
    edges = 0;
    prev_vo = vsync_out;
    for (int i = 0; i < 300; i++) begin
      cyc(1'b0, 4'd0);
      if (vsync_out && !prev_vo) edges++;
      prev_vo = vsync_out;
      if (mode != 4'd3) break;
    end
    check("held_mode2", 32'(mode), 32'd2);
    check("held_edges", 32'(edges), 32'd3);
    measure_mute(muted);
    check("held_muted_cycles", 32'(muted), 32'(MUTE_FRAMES * DE_PER_FRAME));
    wait_idle(300, ok);

    // reset in the middle of muting
    cyc(1'b1, 4'd4);
    wait_mode(4'd4, 200, ok);
    check("to4_applied", 32'(ok), 32'd1);
    repeat (10) cyc(1'b0, 4'd0);
    rst_n = 1'b0;
    cyc(1'b0, 4'd0);
    check("midrst_mode", 32'(mode), 32'd0);
    check("midrst_switching", 32'(switching), 32'd0);
    rst_n = 1'b1;
    muted = 0;
    for (int i = 0; i < 2 * FLEN; i++) begin
      cyc(1'b0, 4'd0);
      if (de_out && (pix_out == 24'd0)) muted++;
    end
    check("midrst_no_mute", 32'(muted), 32'd0);

    // randomized traffic against the model
    rand_de = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      int r;
      r = $urandom_range(99);
      rst_n = ($urandom_range(599) != 0);
      if (r < 3) cyc(1'b1, 4'($urandom_range(MAX_MODE)));
      else if (r == 3) cyc(1'b1, 4'($urandom_range(15, MAX_MODE + 1)));
      else cyc(1'b0, 4'($urandom_range(15)));
    end
    rst_n = 1'b1;
    repeat (4) cyc(1'b0, 4'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/isp_mode_sync.md
Name: isp_mode_sync

Overview:
Frame-synchronous mode controller and output gate in front of the ISP interconnect. It accepts ISP mode requests from the user-interface logic at any time and applies them to the mode bus only at a vertical-sync leading edge. The result pixel stream is forced to black for a programmable number of frames after each switch, so the HDMI sink never sees a torn frame or pipeline-flush garbage. It also registers the pixel stream returning from the interconnect before it goes to the HDMI encoder.

Parameters:
MAX_MODE, 5, highest legal mode code; requests above it are rejected
RESET_MODE, 0, mode driven after reset (0 = ISP bypass)
MUTE_FRAMES, 2, frames blanked after a switch; 0 disables muting; legal range 0..15
VS_POL, 1, vsync polarity; 1 = active high, 0 = active low

Ports:
clk  in  1  pixel clock
rst_n  in  1  synchronous active-low reset
mode_req  in  4  requested ISP mode
mode_req_valid  in  1  single-cycle request strobe
vsync_in  in  1  frame sync from the timing generator
de_in  in  1  data enable, aligned with pix_in
pix_in  in  24  RGB888 from the interconnect result output
mode  out  4  applied mode, to the interconnect mode input
pix_out  out  24  gated pixel to the HDMI encoder
de_out  out  1  registered de_in
vsync_out  out  1  registered vsync_in
switching  out  1  high while a switch is pending or muting
req_err  out  1  one-cycle pulse when a request is rejected

Behaviour:
- Clocking and reset: single clock clk. Reset rst_n is synchronous and active-low.
- Values on reset: mode=RESET_MODE, pix_out=0, de_out=0, vsync_out=0, switching=0, req_err=0, state=IDLE, mute counter=0, pending flag=0.
- Frame edge: vs_n = vsync_in XNOR VS_POL. The frame edge is a one-cycle event where vs_n is asserted and the registered previous vs_n was deasserted.
- Request acceptance:
  - A request is accepted when mode_req_valid=1 and mode_req<=MAX_MODE.
  - If mode_req>MAX_MODE, req_err pulses on the next cycle and state is unchanged.
  - A legal request equal to the applied mode while in IDLE is dropped silently.
  - An accepted request overwrites pend_mode and sets the pending flag. The last request wins.
- State machine:
  - IDLE: an accepted request moves to PENDING.
  - PENDING: on a frame edge, mode<=pend_mode and the pending flag clears. If MUTE_FRAMES>0, the counter loads MUTE_FRAMES and the state moves to MUTE; otherwise it moves to IDLE.
  - MUTE: the counter decrements on each frame edge. When the edge occurs with counter==1, the next state is PENDING if the pending flag is set, else IDLE.
- Simultaneous events:
  - Request and frame edge in the same cycle in PENDING: the edge applies the previous pend_mode. The new request becomes pending, and the state moves to MUTE with the flag set (or to PENDING if MUTE_FRAMES=0).
  - A request during MUTE is held and applied at the first frame edge after muting ends. Mode never changes mid-frame.
- switching = (state != IDLE), registered.
- Pixel path, fixed 1-cycle latency:
  - de_out and vsync_out are de_in and vsync_in delayed one cycle.
  - pix_out = 0 when state==MUTE or de_in==0; otherwise pix_out = pix_in.
  - Muting takes effect on the first pixel after the frame edge that applied the new mode.
- Reset mid-operation: any pending request and mute count are discarded, and mode returns to RESET_MODE on the next clock.

Optional Feature:
ISP_MODE_SYNC_KEY_EN
- When defined:
  - Adds input key_n (1 bit, active-low push button).
  - Debounce: key_n must be stable for 2^20 clk cycles (20-bit counter).
  - Each debounced press generates an internal request for (mode+1), wrapping MAX_MODE->0.
  - A simultaneous mode_req_valid request has priority over the key request.
  - The debounce state resets to "released".
- When undefined: no key_n port and no debounce logic. Requests come only from mode_req.

Test Plan:
- Reset with rst_n=0 for 3 clk -> mode=0, pix_out=0, switching=0. Then send pixels 0x123456 with de=1 -> pix_out=0x123456 one cycle later.
- Request mode 3 mid-frame -> switching=1 next cycle and mode stays 0 until the frame edge. At the edge, mode=3, then pix_out=0 for exactly 2 full frames, then pixels pass and switching=0.
- Request 4 then 5 within one frame -> only mode 5 is applied at the edge. Mode never equals 4.
- Request mode 9 -> req_err high for exactly 1 cycle. Mode and switching are unchanged.
- Request mode 2 during MUTE of a 1->3 switch -> mode=3 until the mute ends, then mode=2 at the following frame edge, then another 2 muted frames.
- Pull rst_n low in the middle of MUTE -> next clock gives mode=0 and switching=0, and pixels pass on the next frame without muting.
